// File: rtl/pc_fetch_unit_pkg.sv
// Shared widths, reset PC, FSM encoding and queue entry layout for the fetch unit.
// No logic; the state enum, entry struct and constants are imported by every fetch file.
package pc_fetch_unit_pkg;

  localparam int          XLEN             = 32;
  localparam int unsigned QDEPTH           = 2;
  localparam int          CNT_W            = 2;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic {
    FETCH_S = 1'b0,
    WAIT_S  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundle of redirect, instruction-memory and decode-side signals of the fetch unit.
// Master is the fetch unit; slave is the memory/decode/next-PC environment.
interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            fetch_busy;

  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_pc, if_instr, fetch_busy
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr, fetch_busy
  );

endinterface

// File: rtl/pc_fetch_unit_fetch_queue.sv
// Two-entry {pc,instr} FIFO with flush; the head is always entry 0 so outputs come from flops.
// Push-to-head latency 1 cycle; caller must never push when full, pop is ignored when empty.
module fetch_queue
  import pc_fetch_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_vld,
  input  fetch_entry_t     push_dat,
  input  logic             pop_vld,
  input  logic             flush_vld,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head_dat
);

  fetch_entry_t     e0_q, e0_d;
  fetch_entry_t     e1_q, e1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] after_pop;
  logic             do_pop;

  always_comb begin
    e0_d      = e0_q;
    e1_d      = e1_q;
    do_pop    = pop_vld && (cnt_q != '0);
    after_pop = cnt_q - {{(CNT_W-1){1'b0}}, do_pop};
    if (do_pop && cnt_q == CNT_W'(QDEPTH)) begin
      e0_d = e1_q;
    end
    // The write slot is chosen after the pop so push+pop on one entry lands in the head.
    if (push_vld) begin
      if (after_pop == '0) e0_d = push_dat;
      else                 e1_d = push_dat;
    end
    cnt_d = after_pop + {{(CNT_W-1){1'b0}}, push_vld};
    if (flush_vld) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign count    = cnt_q;
  assign head_dat = e0_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register, one-outstanding imem FSM with redirect/discard, feeding a 2-entry queue.
// Best case one instruction per 2 cycles; requests stop while queue plus in-flight fill 2 slots.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  pc_fetch_unit_if.master  bus
);

  fetch_state_t     state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic             discard_q, discard_d;
  logic             run_q, run_d;

  logic             space;
  logic             req;
  logic             grant;
  logic             push_vld;
  logic             flush_vld;
  logic             pop_vld;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     head_dat;
  fetch_entry_t     push_dat;
  logic             unused_redirect_lsb;

  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  // run_q keeps imem_req low during reset while staying a pure function of flops.
  assign space = ({1'b0, q_count} + {{CNT_W{1'b0}}, state_q == WAIT_S}) < (CNT_W+1)'(QDEPTH);
  assign req   = run_q && (state_q == FETCH_S) && space;
  assign grant = req && bus.imem_gnt;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    run_d      = 1'b1;
    push_vld   = 1'b0;
    flush_vld  = 1'b0;
    case (state_q)
      FETCH_S: begin
        if (grant) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = WAIT_S;
        end
      end
      WAIT_S: begin
        if (bus.imem_rvalid) begin
          state_d = FETCH_S;
          if (discard_q) discard_d = 1'b0;
          else           push_vld  = 1'b1;
        end
      end
      default: begin
        state_d   = FETCH_S;
        discard_d = 1'b0;
      end
    endcase
    // Redirect overrides the increment and any push; an in-flight response gets dropped.
    if (bus.redirect_valid) begin
      flush_vld  = 1'b1;
      push_vld   = 1'b0;
      fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
      if (state_q == FETCH_S && grant) discard_d = 1'b1;
      else if (state_q == WAIT_S)      discard_d = !bus.imem_rvalid;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= FETCH_S;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      discard_q  <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
      run_q      <= run_d;
    end
  end

  assign push_dat = '{pc: req_pc_q, instr: bus.imem_rdata};
  assign pop_vld  = bus.if_valid && bus.if_ready;

  fetch_queue u_queue (
    .clk       (clk),
    .rstn      (rstn),
    .push_vld  (push_vld),
    .push_dat  (push_dat),
    .pop_vld   (pop_vld),
    .flush_vld (flush_vld),
    .count     (q_count),
    .head_dat  (head_dat)
  );

  assign bus.imem_req   = req;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.if_valid   = (q_count != '0);
  assign bus.if_pc      = head_dat.pc;
  assign bus.if_instr   = head_dat.instr;
  assign bus.fetch_busy = (state_q == WAIT_S);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed cycle table, async-reset sequence, then random traffic
// checked against a program-order model of delivered PCs and issued fetch addresses.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hFFFF_0000;
  endfunction

  typedef struct {
    logic        rstn;
    logic        rv;
    logic [31:0] rpc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_busy;
    logic        hd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rs, input logic rv, input logic [31:0] rpc,
                              input logic gnt, input logic rval, input logic [31:0] rdata,
                              input logic rdy, input logic e_req, input logic [31:0] e_addr,
                              input logic e_vld, input logic [31:0] e_pc,
                              input logic [31:0] e_instr, input logic e_busy, input logic hd);
    vec_t v;
    v.rstn = rs; v.rv = rv; v.rpc = rpc; v.gnt = gnt; v.rvalid = rval; v.rdata = rdata;
    v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
    v.e_instr = e_instr; v.e_busy = e_busy; v.hd = hd;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic rv, input logic [31:0] rpc, input logic gnt,
                       input logic rval, input logic [31:0] rdata, input logic rdy);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.imem_gnt       = gnt;
    bus.imem_rvalid    = rval;
    bus.imem_rdata     = rdata;
    bus.if_ready       = rdy;
  endtask

  task automatic chk_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                          input logic e_vld, input logic [31:0] e_pc, input logic [31:0] e_instr,
                          input logic e_busy, input logic hd);
    chk({tag, " imem_req"},   32'(bus.imem_req),   32'(e_req));
    chk({tag, " imem_addr"},  bus.imem_addr,       e_addr);
    chk({tag, " if_valid"},   32'(bus.if_valid),   32'(e_vld));
    chk({tag, " fetch_busy"}, 32'(bus.fetch_busy), 32'(e_busy));
    if (hd) begin
      chk({tag, " if_pc"},    bus.if_pc,    e_pc);
      chk({tag, " if_instr"}, bus.if_instr, e_instr);
    end
  endtask

  // random-phase model state
  logic [31:0] exp_pc, exp_fetch, paddr, rpc;
  logic        pending, rv, gnt, rval, rdy;
  logic [31:0] rdata;
  int          lat, ndel;

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // rstn, rv, rpc, gnt, rvalid, rdata, rdy | req, addr, vld, pc, instr, busy, head-checked
    add(0,0,0,          0,0,0,                  0, 0,32'h3000,     0,0,0,0,1);
    add(0,0,0,          0,0,0,                  0, 0,32'h3000,     0,0,0,0,1);
    add(0,0,0,          0,0,0,                  0, 0,32'h3000,     0,0,0,0,1);
    add(1,0,0,          1,0,0,                  1, 0,32'h3000,     0,0,0,0,1);
    add(1,0,0,          1,0,0,                  1, 1,32'h3000,     0,0,0,0,1);
    add(1,0,0,          1,1,memf(32'h3000),     1, 0,32'h3004,     0,0,0,1,0);
    add(1,0,0,          1,0,0,                  1, 1,32'h3004,     1,32'h3000,memf(32'h3000),0,1);
    add(1,0,0,          1,1,memf(32'h3004),     1, 0,32'h3008,     0,0,0,1,0);
    add(1,0,0,          1,0,0,                  1, 1,32'h3008,     1,32'h3004,memf(32'h3004),0,1);
    add(1,0,0,          1,1,memf(32'h3008),     1, 0,32'h300C,     0,0,0,1,0);
    add(1,0,0,          1,0,0,                  0, 1,32'h300C,     1,32'h3008,memf(32'h3008),0,1);
    add(1,0,0,          1,1,memf(32'h300C),     0, 0,32'h3010,     1,32'h3008,memf(32'h3008),1,1);
    add(1,0,0,          1,0,0,                  0, 0,32'h3010,     1,32'h3008,memf(32'h3008),0,1);
    add(1,0,0,          1,0,0,                  1, 0,32'h3010,     1,32'h3008,memf(32'h3008),0,1);
    add(1,0,0,          1,0,0,                  1, 1,32'h3010,     1,32'h300C,memf(32'h300C),0,1);
    add(1,1,32'h0040_0013, 0,0,0,               1, 0,32'h3014,     0,0,0,1,0);
    add(1,0,0,          1,1,memf(32'h3010),     1, 0,32'h0040_0010,0,0,0,1,0);
    add(1,0,0,          1,0,0,                  1, 1,32'h0040_0010,0,0,0,0,0);
    add(1,0,0,          1,1,memf(32'h0040_0010),1, 0,32'h0040_0014,0,0,0,1,0);
    add(1,1,32'h100,    1,0,0,                  1, 1,32'h0040_0014,1,32'h0040_0010,memf(32'h0040_0010),0,1);
    add(1,0,0,          1,1,memf(32'h0040_0014),1, 0,32'h100,      0,0,0,1,0);
    add(1,0,0,          1,0,0,                  1, 1,32'h100,      0,0,0,0,0);
    add(1,1,32'h100,    1,1,memf(32'h100),      1, 0,32'h104,      0,0,0,1,0);
    add(1,0,0,          1,0,0,                  1, 1,32'h100,      0,0,0,0,0);
    add(1,0,0,          1,1,memf(32'h100),      1, 0,32'h104,      0,0,0,1,0);
    add(1,1,32'hFFFF_FFFC, 0,0,0,               1, 1,32'h104,      1,32'h100,memf(32'h100),0,1);
    add(1,0,0,          0,0,0,                  1, 1,32'hFFFF_FFFC,0,0,0,0,0);
    add(1,0,0,          0,0,0,                  1, 1,32'hFFFF_FFFC,0,0,0,0,0);
    add(1,0,0,          0,0,0,                  1, 1,32'hFFFF_FFFC,0,0,0,0,0);
    add(1,0,0,          1,0,0,                  1, 1,32'hFFFF_FFFC,0,0,0,0,0);
    add(1,0,0,          1,1,memf(32'hFFFF_FFFC),1, 0,32'h0,        0,0,0,1,0);
    add(1,0,0,          1,0,0,                  1, 1,32'h0,        1,32'hFFFF_FFFC,32'h0000_FFFC,0,1);
    add(1,0,0,          1,1,memf(32'h0),        1, 0,32'h4,        0,0,0,1,0);
    add(1,0,0,          0,0,0,                  1, 1,32'h4,        1,32'h0,32'hFFFF_0000,0,1);
    add(1,0,0,          0,0,0,                  1, 1,32'h4,        0,0,0,0,0);

    foreach (tbl[i]) begin
      @(negedge clk);
      chk_outs($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld,
               tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_busy, tbl[i].hd);
      rstn = tbl[i].rstn;
      drive(tbl[i].rv, tbl[i].rpc, tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, tbl[i].rdy);
    end

    // async reset between gnt and rvalid; the late rvalid must be ignored
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("arst busy_before", 32'(bus.fetch_busy), 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    #2 rstn = 1'b0;
    #1 chk_outs("arst immediate", 1'b0, 32'h3000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk_outs("arst restart", 1'b1, 32'h3000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    chk_outs("arst stray_rvalid", 1'b1, 32'h3000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk_outs("arst granted", 1'b0, 32'h3004, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, memf(32'h3000), 1'b0);
    @(negedge clk);
    chk_outs("arst first", 1'b1, 32'h3004, 1'b1, 32'h3000, memf(32'h3000), 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // random traffic against a program-order model
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn      = 1'b1;
    exp_pc    = 32'h3000;
    exp_fetch = 32'h3000;
    pending   = 1'b0;
    paddr     = 32'h0;
    lat       = 0;
    ndel      = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (pending) chk("rnd single_outstanding", 32'(bus.imem_req), 32'd0);
      chk("rnd fetch_busy", 32'(bus.fetch_busy), 32'(pending));

      rval  = 1'b0;
      rdata = $urandom;
      if (pending) begin
        if (lat <= 1) begin
          rval    = 1'b1;
          rdata   = memf(paddr);
          pending = 1'b0;
        end else begin
          lat--;
        end
      end

      gnt = 1'b0;
      if (bus.imem_req) begin
        if (($urandom % 3) != 0) begin
          gnt = 1'b1;
          chk("rnd fetch_addr", bus.imem_addr, exp_fetch);
          exp_fetch = exp_fetch + 32'd4;
          paddr     = bus.imem_addr;
          pending   = 1'b1;
          lat       = int'($urandom_range(1, 3));
        end
      end else begin
        gnt = (($urandom % 8) == 0);
      end

      rdy = (($urandom % 4) != 0);
      if (bus.if_valid && rdy) begin
        chk("rnd if_pc", bus.if_pc, exp_pc);
        chk("rnd if_instr", bus.if_instr, memf(exp_pc));
        exp_pc = exp_pc + 32'd4;
        ndel++;
      end

      rv  = (($urandom % 20) == 0);
      rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      if (rv) begin
        exp_pc    = {rpc[31:2], 2'b00};
        exp_fetch = {rpc[31:2], 2'b00};
      end
      drive(rv, rpc, gnt, rval, rdata, rdy);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("rnd progress", 32'(ndel > 200), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
